// File: rtl/ma_peak_detector.sv
// Peak detector for the smoothed sample stream: level-gated candidate tracking,
// hysteresis-confirmed maxima, refractory window, and peak readout registers.
module ma_peak_detector #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned MIN_LEVEL = 32,
   parameter int unsigned HYST      = 4,
   parameter int unsigned REFRACT   = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             peak_valid,
   output logic [WIDTH-1:0] peak_value,
   output logic [CNT_W-1:0] peak_index,
   output logic [CNT_W-1:0] peak_count,
   output logic [1:0]       state_o
);

   localparam int unsigned RC_W = (REFRACT < 2) ? 1 : $clog2(REFRACT + 1);

   typedef enum logic [1:0] {
      S_SEARCH  = 2'd0,
      S_TRACK   = 2'd1,
      S_REFRACT = 2'd2
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_sample_idx;
   logic [WIDTH-1:0] r_max_val;
   logic [CNT_W-1:0] r_max_idx;
   logic [RC_W-1:0]  r_refract_cnt;
   logic             r_peak_valid;
   logic [WIDTH-1:0] r_peak_value;
   logic [CNT_W-1:0] r_peak_index;
   logic [CNT_W-1:0] r_peak_count;

   state_t           w_state_nxt;
   logic [WIDTH-1:0] w_max_val_nxt;
   logic [CNT_W-1:0] w_max_idx_nxt;
   logic [RC_W-1:0]  w_refract_nxt;
   logic             w_confirm;
   logic [WIDTH-1:0] w_drop;

   always_comb begin
      w_state_nxt   = r_state;
      w_max_val_nxt = r_max_val;
      w_max_idx_nxt = r_max_idx;
      w_refract_nxt = r_refract_cnt;
      w_confirm     = 1'b0;
      // Only meaningful in the non-rising TRACK branch, where it cannot underflow.
      w_drop        = r_max_val - in_data;
      if (in_valid) begin
         case (r_state)
            S_SEARCH: begin
               if (32'(in_data) >= MIN_LEVEL) begin
                  w_state_nxt   = S_TRACK;
                  w_max_val_nxt = in_data;
                  w_max_idx_nxt = r_sample_idx;
               end
            end
            S_TRACK: begin
               if (in_data > r_max_val) begin
                  w_max_val_nxt = in_data;
                  w_max_idx_nxt = r_sample_idx;
               end else if (32'(w_drop) >= HYST) begin
                  w_confirm = 1'b1;
                  if (REFRACT > 0) begin
                     w_state_nxt   = S_REFRACT;
                     w_refract_nxt = RC_W'(REFRACT);
                  end else begin
                     w_state_nxt = S_SEARCH;
                  end
               end
            end
            S_REFRACT: begin
               w_refract_nxt = r_refract_cnt - RC_W'(1);
               if (r_refract_cnt == RC_W'(1)) begin
                  w_state_nxt = S_SEARCH;
               end
            end
            default: begin
               w_state_nxt = S_SEARCH;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_SEARCH;
         r_sample_idx  <= '0;
         r_max_val     <= '0;
         r_max_idx     <= '0;
         r_refract_cnt <= '0;
         r_peak_valid  <= 1'b0;
         r_peak_value  <= '0;
         r_peak_index  <= '0;
         r_peak_count  <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_max_val     <= w_max_val_nxt;
         r_max_idx     <= w_max_idx_nxt;
         r_refract_cnt <= w_refract_nxt;
         r_peak_valid  <= w_confirm;
         if (in_valid) begin
            r_sample_idx <= r_sample_idx + CNT_W'(1);
         end
         if (w_confirm) begin
            r_peak_value <= r_max_val;
            r_peak_index <= r_max_idx;
            if (r_peak_count != '1) begin
               r_peak_count <= r_peak_count + CNT_W'(1);
            end
         end
      end
   end

   assign peak_valid = r_peak_valid;
   assign peak_value = r_peak_value;
   assign peak_index = r_peak_index;
   assign peak_count = r_peak_count;
   assign state_o    = r_state;

endmodule
